// File: rtl/gpu_raster_if.sv
// Command and framebuffer port bundle for the raster engine.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// the master holds every cmd_* field stable while cmd_valid is high, and the
// engine latches all fields on the transfer edge, so they may change afterwards.
interface gpu_raster_if #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int PW = 1
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [XW-1:0] X1;
    logic [XW-1:0] X2;
    logic [YW-1:0] Y1;
    logic [YW-1:0] Y2;
    logic [XW-1:0] SX;
    logic [YW-1:0] SY;
    logic [PW-1:0] fill_value;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [PW-1:0] rd_data;
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [PW-1:0] wr_data;

    // Engine side.
    modport slave (
        input  cmd_valid, cmd_op, X1, X2, Y1, Y2, SX, SY, fill_value, rd_data,
        output cmd_ready, busy, done, err, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
    );

    // Command source / framebuffer side.
    modport master (
        output cmd_valid, cmd_op, X1, X2, Y1, Y2, SX, SY, fill_value, rd_data,
        input  cmd_ready, busy, done, err, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
    );
endinterface

// File: rtl/gpu_raster_engine.sv
// Rectangle raster engine: solid fill, blit and XOR fill over a framebuffer
// with separate read and write pixel ports. One command at a time, pixels are
// visited row-major; blit/XOR do a strict read-then-write per pixel.
module gpu_raster_engine #(
    parameter int XW     = 9,
    parameter int YW     = 8,
    parameter int PW     = 1,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    gpu_raster_if.slave        bus,
    output logic [2:0]         dbg_state
);
    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_BLIT = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam int         WCW     = $clog2(RD_LAT + 1);

    // Completion returns straight to IDLE with done registered, so the done
    // cycle is already an accepting cycle.
    typedef enum logic [2:0] {IDLE, CHECK, FILL, RD, WAIT, WR} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [XW-1:0] rd_x_q, rd_x_d, wr_x_q, wr_x_d;
    logic [YW-1:0] rd_y_q, rd_y_d, wr_y_q, wr_y_d;
    logic [PW-1:0] wr_data_q, wr_data_d, fv_q, fv_d;
    logic [1:0]    op_q, op_d;
    logic [XW-1:0] x1_q, x1_d, x2_q, x2_d, sx0_q, sx0_d, cx_q, cx_d, sx_q, sx_d;
    logic [YW-1:0] y1_q, y1_d, y2_q, y2_d, sy0_q, sy0_d, cy_q, cy_d, sy_q, sy_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;

    logic          last_x, last_pix, reject;
    logic [XW:0]   sx_end;
    logic [YW:0]   sy_end;
    logic [XW-1:0] nx, nsx;
    logic [YW-1:0] ny, nsy;

    assign bus.cmd_ready = (state_q == IDLE) && !reset;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_x      = rd_x_q;
    assign bus.rd_y      = rd_y_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_x      = wr_x_q;
    assign bus.wr_y      = wr_y_q;
    assign bus.wr_data   = wr_data_q;
    assign dbg_state     = state_q;

    // Next-state, scan stepping and validity checks; last-pixel tests compare
    // against X2/Y2 so a rectangle reaching the top coordinate still ends.
    always_comb begin
        state_d = state_q;   busy_d = busy_q;   done_d = 1'b0;   err_d = 1'b0;
        rd_en_d = 1'b0;      rd_x_d = rd_x_q;   rd_y_d = rd_y_q;
        wr_en_d = 1'b0;      wr_x_d = wr_x_q;   wr_y_d = wr_y_q; wr_data_d = wr_data_q;
        op_d = op_q;   fv_d = fv_q;   x1_d = x1_q;   x2_d = x2_q;   y1_d = y1_q;   y2_d = y2_q;
        sx0_d = sx0_q; sy0_d = sy0_q; cx_d = cx_q;   cy_d = cy_q;   sx_d = sx_q;   sy_d = sy_q;
        wcnt_d = wcnt_q;

        last_x   = (cx_q == x2_q);
        last_pix = last_x && (cy_q == y2_q);
        nx       = last_x ? x1_q : cx_q + 1'b1;
        ny       = last_x ? cy_q + 1'b1 : cy_q;
        nsx      = last_x ? sx0_q : sx_q + 1'b1;
        nsy      = last_x ? sy_q + 1'b1 : sy_q;
        sx_end   = {1'b0, sx0_q} + {1'b0, x2_q - x1_q};
        sy_end   = {1'b0, sy0_q} + {1'b0, y2_q - y1_q};
        reject   = (x1_q > x2_q) || (y1_q > y2_q) || (op_q == OP_RSVD) ||
                   ((op_q == OP_BLIT) && (sx_end[XW] || sy_end[YW]));

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    op_d  = bus.cmd_op;  fv_d = bus.fill_value;
                    x1_d  = bus.X1;      x2_d = bus.X2;
                    y1_d  = bus.Y1;      y2_d = bus.Y2;
                    // XOR reads its own destination, so its source origin is X1/Y1.
                    sx0_d = (bus.cmd_op == OP_XOR) ? bus.X1 : bus.SX;
                    sy0_d = (bus.cmd_op == OP_XOR) ? bus.Y1 : bus.SY;
                    cx_d  = bus.X1;      cy_d = bus.Y1;
                    sx_d  = sx0_d;       sy_d = sy0_d;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    err_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
                end else if (op_q == OP_FILL) begin
                    wr_en_d = 1'b1;  wr_x_d = cx_q;  wr_y_d = cy_q;  wr_data_d = fv_q;
                    state_d = FILL;
                end else begin
                    rd_en_d = 1'b1;  rd_x_d = sx_q;  rd_y_d = sy_q;
                    state_d = RD;
                end
            end
            FILL: begin
                if (last_pix) begin
                    done_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
                end else begin
                    cx_d = nx;  cy_d = ny;
                    wr_en_d = 1'b1;  wr_x_d = nx;  wr_y_d = ny;
                end
            end
            RD: begin
                wcnt_d  = WCW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == WCW'(RD_LAT)) begin
                    wr_en_d   = 1'b1;  wr_x_d = cx_q;  wr_y_d = cy_q;
                    wr_data_d = (op_q == OP_XOR) ? (bus.rd_data ^ fv_q) : bus.rd_data;
                    state_d   = WR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            WR: begin
                if (last_pix) begin
                    done_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
                end else begin
                    cx_d = nx;  cy_d = ny;  sx_d = nsx;  sy_d = nsy;
                    rd_en_d = 1'b1;  rd_x_d = nsx;  rd_y_d = nsy;
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any command with no done/err pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
            rd_en_q <= 1'b0;  rd_x_q <= '0;    rd_y_q <= '0;
            wr_en_q <= 1'b0;  wr_x_q <= '0;    wr_y_q <= '0;    wr_data_q <= '0;
            op_q <= '0;   fv_q <= '0;   x1_q <= '0;   x2_q <= '0;   y1_q <= '0;   y2_q <= '0;
            sx0_q <= '0;  sy0_q <= '0;  cx_q <= '0;   cy_q <= '0;   sx_q <= '0;   sy_q <= '0;
            wcnt_q <= '0;
        end else begin
            state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;  err_q <= err_d;
            rd_en_q <= rd_en_d;  rd_x_q <= rd_x_d;  rd_y_q <= rd_y_d;
            wr_en_q <= wr_en_d;  wr_x_q <= wr_x_d;  wr_y_q <= wr_y_d;  wr_data_q <= wr_data_d;
            op_q <= op_d;   fv_q <= fv_d;   x1_q <= x1_d;   x2_q <= x2_d;   y1_q <= y1_d;   y2_q <= y2_d;
            sx0_q <= sx0_d; sy0_q <= sy0_d; cx_q <= cx_d;   cy_q <= cy_d;   sx_q <= sx_d;   sy_q <= sy_d;
            wcnt_q <= wcnt_d;
        end
    end
endmodule
